// File: rtl/lut_logic_block_pkg.sv
// Shared types and size derivations for the LUT logic block.
package lut_logic_block_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Bits per cell: 2^K truth-table bits plus one reg_mode bit.
  function automatic int unsigned cell_w_f(input int unsigned k);
    return (32'd1 << k) + 32'd1;
  endfunction

  // Total configuration bits across all cells.
  function automatic int unsigned cfg_bits_f(input int unsigned k, input int unsigned n);
    return n * cell_w_f(k);
  endfunction

  // Number of configuration words needed to cover all bits (ceiling division).
  function automatic int unsigned nwords_f(input int unsigned k, input int unsigned n,
                                           input int unsigned cfg_w);
    return (cfg_bits_f(k, n) + cfg_w - 32'd1) / cfg_w;
  endfunction

endpackage

// File: rtl/lut_logic_block_cell.sv
// One K-input LUT: active truth table, reg_mode bit and the optional output flop.
module lut_cell
  import lut_logic_block_pkg::*;
#(
  parameter int unsigned K = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [cell_w_f(K)-1:0] cfg_i,
  input  logic                   ce_i,
  input  logic [K-1:0]           operand_i,
  output logic                   result_o
);

  localparam int unsigned TT_W = 32'd1 << K;

  logic [TT_W-1:0] table_q;
  logic            mode_q;
  logic            out_q;
  logic            lut_val_c;

  // Table lookup with the operand slice as an unsigned index.
  always_comb begin
    lut_val_c = table_q[operand_i];
  end

  // Active config swaps atomically on load; output flop follows ce with the current table.
  always_ff @(posedge clk) begin
    if (!rst) begin
      table_q <= '0;
      mode_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      if (load_i) begin
        table_q <= cfg_i[TT_W-1:0];
        mode_q  <= cfg_i[TT_W];
      end
      if (ce_i) begin
        out_q <= lut_val_c;
      end
    end
  end

  // Select registered or combinational output.
  always_comb begin
    result_o = mode_q ? out_q : lut_val_c;
  end

endmodule

// File: rtl/lut_logic_block.sv
// Array of N configurable LUTs with a word-serial shadow configuration loader.
module lut_logic_block
  import lut_logic_block_pkg::*;
#(
  parameter int unsigned K     = 4,
  parameter int unsigned N     = 2,
  parameter int unsigned CFG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             config_start,
  input  logic             config_valid,
  input  logic [CFG_W-1:0] config_data,
  output logic             config_ready,
  output logic             config_done,
  input  logic             ce,
  input  logic [N*K-1:0]   operands,
  output logic [N-1:0]     result
);

  localparam int unsigned CELL_W   = cell_w_f(K);
  localparam int unsigned NWORDS   = nwords_f(K, N, CFG_W);
  localparam int unsigned SHADOW_W = NWORDS * CFG_W;
  localparam int unsigned CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                done_q;
  logic                ready_c;
  logic                commit_c;

  // Loader state, word counter, shadow and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      done_q   <= commit_c;
    end
  end

  // Next-state logic; shadow_d already holds the final word on the commit cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ready_c  = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (config_start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        if (config_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else begin
          ready_c = 1'b1;
          if (config_valid) begin
            for (int unsigned w = 0; w < NWORDS; w++) begin
              if (cnt_q == CNT_W'(w)) begin
                shadow_d[w*CFG_W +: CFG_W] = config_data;
              end
            end
            if (cnt_q == CNT_W'(NWORDS - 1)) begin
              commit_c = 1'b1;
              cnt_d    = '0;
              state_d  = RUN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign config_ready = ready_c;
  assign config_done  = done_q;

  // One cell per LUT; all cells swap config on the same commit edge.
  for (genvar i = 0; i < N; i++) begin : g_cell
    lut_cell #(
      .K(K)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .load_i   (commit_c),
      .cfg_i    (shadow_d[i*CELL_W +: CELL_W]),
      .ce_i     (ce),
      .operand_i(operands[i*K +: K]),
      .result_o (result[i])
    );
  end

endmodule
